// File: rtl/dc_stage_skid.sv
// Decode/dispatch stage with an output skid FIFO.
// Decodes one RV32IMF instruction per cycle, drives the arch registers to rename,
// gates dispatch on ROB/LQ/SQ credit and FIFO space, and stores the renamed bundle
// in a small FIFO that offers IS a registered valid/ready interface.
module dc_stage_skid #(
    parameter int PREG_W     = 7,
    parameter int ROB_W      = 3,
    parameter int LSQ_W      = 2,
    parameter int SKID_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IF_valid,
    output logic              DC_ready,
    input  logic [31:0]       DC_in_pc,
    input  logic [31:0]       DC_in_inst,
    input  logic              DC_in_jump,
    output logic [5:0]        A_rs1,
    output logic [5:0]        A_rs2,
    output logic [5:0]        A_rd,
    output logic              allocate_rd,
    input  logic [PREG_W-1:0] P_rs1,
    input  logic [PREG_W-1:0] P_rs2,
    input  logic [PREG_W-1:0] P_rd_new,
    input  logic [PREG_W-1:0] P_rd_old,
    input  logic              rob_ready,
    input  logic [ROB_W-1:0]  DC_rob_idx,
    output logic              decode_valid,
    output logic [2:0]        DC_fu_sel,
    output logic [PREG_W-1:0] DC_P_rd_old,
    input  logic [LSQ_W-1:0]  LQ_tail,
    input  logic [LSQ_W-1:0]  SQ_tail,
    input  logic              ld_ready,
    input  logic              st_ready,
    input  logic              mispredict,
    input  logic              stall,
    output logic              DC_valid,
    input  logic              IS_ready,
    output logic [31:0]       DC_out_pc,
    output logic [31:0]       DC_out_inst,
    output logic [31:0]       DC_out_imm,
    output logic [4:0]        DC_out_op,
    output logic [2:0]        DC_out_f3,
    output logic [6:0]        DC_out_f7,
    output logic [PREG_W-1:0] DC_out_P_rs1,
    output logic [PREG_W-1:0] DC_out_P_rs2,
    output logic [PREG_W-1:0] DC_out_P_rd,
    output logic [2:0]        DC_out_fu_sel,
    output logic [ROB_W-1:0]  DC_out_rob_idx,
    output logic [LSQ_W-1:0]  DC_out_LQ_tail,
    output logic [LSQ_W-1:0]  DC_out_SQ_tail,
    output logic              DC_out_jump
);

    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(SKID_DEPTH);

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_FLOAD  = 5'b00001;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_FSTORE = 5'b01001;
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_FP     = 5'b10100;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       inst;
        logic [31:0]       imm;
        logic [4:0]        op;
        logic [2:0]        f3;
        logic [6:0]        f7;
        logic [PREG_W-1:0] p_rs1;
        logic [PREG_W-1:0] p_rs2;
        logic [PREG_W-1:0] p_rd;
        logic [2:0]        fu_sel;
        logic [ROB_W-1:0]  rob_idx;
        logic [LSQ_W-1:0]  lq_tail;
        logic [LSQ_W-1:0]  sq_tail;
        logic              jump;
    } bundle_t;

    bundle_t           mem [SKID_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [4:0]  op;
    logic [31:0] imm;
    logic        is_load;
    logic        is_store;
    logic        push;
    logic        pop;
    bundle_t     new_bundle;
    bundle_t     head;

    // Instruction decode: arch regs, FU class and immediate.
    always_comb begin
        op       = DC_in_inst[6:2];
        is_load  = (op == OP_LOAD) || (op == OP_FLOAD);
        is_store = (op == OP_STORE) || (op == OP_FSTORE);
        A_rs1    = {op == OP_FP, DC_in_inst[19:15]};
        A_rs2    = {(op == OP_FP) || (op == OP_FSTORE), DC_in_inst[24:20]};
        A_rd     = {(op == OP_FP) || (op == OP_FLOAD), DC_in_inst[11:7]};
        allocate_rd = !(is_store || (op == OP_BRANCH)) && (A_rd != 6'd0);

        DC_fu_sel = 3'd0;
        if (op == OP_R)
            DC_fu_sel = {2'b00, DC_in_inst[25]};
        else if (op == OP_FP)
            DC_fu_sel = 3'd3;
        else if (is_load)
            DC_fu_sel = 3'd6;
        else if (is_store)
            DC_fu_sel = 3'd7;

        case (op)
            OP_LOAD, OP_FLOAD, OP_IMM, OP_JALR:
                imm = {{20{DC_in_inst[31]}}, DC_in_inst[31:20]};
            OP_STORE, OP_FSTORE:
                imm = {{20{DC_in_inst[31]}}, DC_in_inst[31:25], DC_in_inst[11:7]};
            OP_BRANCH:
                imm = {{19{DC_in_inst[31]}}, DC_in_inst[31], DC_in_inst[7],
                       DC_in_inst[30:25], DC_in_inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {DC_in_inst[31:12], 12'b0};
            OP_JAL:
                imm = {{11{DC_in_inst[31]}}, DC_in_inst[31], DC_in_inst[19:12],
                       DC_in_inst[20], DC_in_inst[30:21], 1'b0};
            OP_SYSTEM:
                imm = {20'b0, DC_in_inst[31:20]};
            default:
                imm = 32'd0;
        endcase
    end

    // Dispatch gating and FIFO handshake; space uses the registered count only,
    // so a full FIFO being popped this cycle still refuses a push.
    always_comb begin
        DC_ready = rob_ready
                 & (!is_load  || ld_ready)
                 & (!is_store || st_ready)
                 & (count < DEPTH_C)
                 & !mispredict
                 & !stall;
        decode_valid = IF_valid & DC_ready;
        push         = decode_valid;
        pop          = DC_valid & IS_ready & !mispredict;
        DC_P_rd_old  = P_rd_old;

        new_bundle.pc      = DC_in_pc;
        new_bundle.inst    = DC_in_inst;
        new_bundle.imm     = imm;
        new_bundle.op      = op;
        new_bundle.f3      = DC_in_inst[14:12];
        new_bundle.f7      = DC_in_inst[31:25];
        new_bundle.p_rs1   = P_rs1;
        new_bundle.p_rs2   = P_rs2;
        new_bundle.p_rd    = P_rd_new;
        new_bundle.fu_sel  = DC_fu_sel;
        new_bundle.rob_idx = DC_rob_idx;
        new_bundle.lq_tail = LQ_tail;
        new_bundle.sq_tail = SQ_tail;
        new_bundle.jump    = DC_in_jump;
    end

    // FIFO storage, pointers and occupancy; flush resets pointers but keeps contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < SKID_DEPTH; i++)
                mem[i] <= '0;
        end else if (mispredict) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_bundle;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head-of-FIFO outputs to IS.
    always_comb begin
        head           = mem[rd_ptr];
        DC_valid       = (count != '0);
        DC_out_pc      = head.pc;
        DC_out_inst    = head.inst;
        DC_out_imm     = head.imm;
        DC_out_op      = head.op;
        DC_out_f3      = head.f3;
        DC_out_f7      = head.f7;
        DC_out_P_rs1   = head.p_rs1;
        DC_out_P_rs2   = head.p_rs2;
        DC_out_P_rd    = head.p_rd;
        DC_out_fu_sel  = head.fu_sel;
        DC_out_rob_idx = head.rob_idx;
        DC_out_LQ_tail = head.lq_tail;
        DC_out_SQ_tail = head.sq_tail;
        DC_out_jump    = head.jump;
    end

endmodule
